spi_memory_p: RTL and testbench
===============================

// Module: spi_memory_p
// PURPOSE
//  Parametrised SPI-slave memory: successor to the 8-bit mode-0 SPI memory.
//  - Serial header carries address + R/W; data frames follow in a burst.
//  - Burst address auto-increments and wraps.
//  - Data width, depth and SPI mode (CPOL/CPHA) are generic.
//  - Sits between the FPGA pins and the on-chip RAM; one FPGA clock domain.
// PARAMETERS
//  DATA_W      8    data frame width, bits (>=2)
//  DEPTH       128  memory words
//  ADDR_W      7    address bits; DEPTH <= 2**ADDR_W
//  CPOL        0    SCLK idle level
//  CPHA        0    0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES 2    synchroniser flops per pin (>=2)
// PORTS
//  clk       in   1  FPGA clock; all logic on posedge
//  reset     in   1  synchronous, active-high
//  sclk_pin  in   1  SPI clock (asynchronous)
//  cs_pin    in   1  SPI chip select, active-low (asynchronous)
//  mosi_pin  in   1  master out, slave in (asynchronous)
//  miso_pin  out  1  master in, slave out; 1'bz when not driving
//  leds      out  4  debug: current state encoding
// BEHAVIOUR
//  - Sync: each pin passes through SYNC_STAGES flops, then 1 history flop.
//    - sample_ev / shift_ev are 1-clk pulses on the mode-selected SCLK edges.
//    - Pin-to-pulse latency is SYNC_STAGES+1 clk.
//    - Every SCLK half-period must be >= 4 clk.
//  - Edge pulses are ignored while synced cs is high.
//  - Header: ADDR_W+1 bits, MSB first, taken on sample_ev.
//    - Header = {addr[ADDR_W-1:0], rw}; rw=1 read, 0 write.
//  - Data: DATA_W-bit frames, MSB first; frames repeat until cs rises.
//  - States:
//    - IDLE:   cs fall -> HDR; bit counter cleared.
//    - HDR:    on last header bit, latch addr.
//              - rw=0 -> WR.
//              - rw=1 -> RD_FETCH.
//    - RD_FETCH: one-cycle RAM read at addr.
//              - Next clk: load shift reg, miso_oe=1.
//              - -> RD_SHIFT.
//    - RD_SHIFT: shift_ev drives next bit on MISO.
//              - First shift_ev after load presents MSB.
//              - After DATA_W bits: addr++ -> RD_FETCH.
//              - Prefetch completes within 2 clk, before the next shift_ev.
//    - WR:     sample_ev shifts MOSI in.
//              - After DATA_W bits -> WR_COMMIT.
//    - WR_COMMIT: one-clk write at addr; addr++ -> WR.
//  - Address increment:
//    - addr == DEPTH-1 wraps to 0.
//    - Header address >= DEPTH is reduced modulo DEPTH.
//  - cs rise (synced), any state except IDLE -> IDLE next clk.
//    - miso_pin -> z; partial frame discarded; no RAM write.
//    - A frame whose last sample_ev coincides with cs rise is discarded.
//  - Reset (any state, mid-frame included):
//    - state=IDLE, counters=0, addr=0, shift reg=0, miso_pin=z.
//    - Synchroniser flops: cs chain=1, sclk chain=CPOL, mosi chain=0.
//    - RAM contents are NOT reset.
//  - miso_pin is driven only in RD_FETCH/RD_SHIFT, else 1'bz.
//  - leds: IDLE=0, HDR=1, RD_FETCH=2, RD_SHIFT=3, WR=4, WR_COMMIT=5.
// STRUCTURE
//  - Shared package spi_mem_pkg:
//    - state encoding localparams.
//    - RW_READ=1'b1.
//    - Mode-to-edge selection function (CPOL,CPHA -> sample/shift polarity).
//  - Sub-module spi_pin_sync #(SYNC_STAGES,RESET_VAL): per-pin synchroniser
//    with rise/fall pulse outputs; instantiated three times.
//  - Top level holds FSM, bit counter, shift register, address counter,
//    RAM array.
// TESTING
//  1. Mode 0, DATA_W=8: write hdr {7'h12,0}, data 8'hA5, cs high.
//     Then read hdr {7'h12,1} -> MISO returns A5 MSB first;
//     miso_pin=z between transfers.
//  2. Burst write addr 7'h7E, data 11,22,33 -> RAM[7E]=11, RAM[7F]=22,
//     RAM[00]=33 (wrap).
//     Burst read from 7E returns 11,22,33.
//  3. cs raised after 5 data bits of a write to 7'h05 (RAM[05]=3C)
//     -> RAM[05] stays 3C; state IDLE within SYNC_STAGES+2 clk.
//  4. Reset asserted mid-read: leds=0 and miso_pin=z next clk.
//     Next transaction starts cleanly; RAM contents unchanged.
//  5. Each mode (CPOL,CPHA) in {00,01,10,11}, DATA_W=16, DEPTH=32:
//     write 16'hBEEF at 5'h03, read back BEEF.
//     Master samples per mode; no bit slip.
//  6. SCLK half-period exactly 4 clk, 4-word read burst: all words correct.
//     Prefetch never late (checker: MISO stable before each sample edge).

Source files
------------

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
//   Shared definitions for the SPI-slave memory:
//   - state_e  : FSM state encoding, also the debug LED code
//   - RW_READ  : value of the header R/W bit that selects a read
//   - sample_on_rise() : maps SPI mode (CPOL, CPHA) to the SCLK edge
//     on which MOSI is sampled; MISO is shifted on the opposite edge.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_RD_FETCH  = 3'd2,
    ST_RD_SHIFT  = 3'd3,
    ST_WR        = 3'd4,
    ST_WR_COMMIT = 3'd5
  } state_e;

  localparam logic RW_READ = 1'b1;

  // Leading edge is the transition away from the idle level (CPOL).
  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge, so
  // sampling lands on the rising edge exactly when CPOL equals CPHA.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
//   Brings one asynchronous SPI pin into the clk domain: SYNC_STAGES
//   synchroniser flops followed by one history flop used for edge detect.
//   Ports:
//     clk, reset  : FPGA clock, synchronous active-high reset
//     pin         : asynchronous input pin
//     level       : synchronised pin level
//     rise, fall  : one-clk pulses on synchronised rising / falling edges
//   All flops reset to RESET_VAL so that no edge is reported on reset exit
//   while the pin sits at its idle level.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_memory_p.sv
// spi_memory_p
//   SPI-slave memory. A transaction is cs low, an (ADDR_W+1)-bit header
//   {addr, rw} MSB first, then DATA_W-bit frames until cs rises. Writes
//   store each completed frame; reads stream words out. The burst address
//   increments after every frame and wraps from DEPTH-1 to 0.
//   Ports:
//     clk, reset : FPGA clock, synchronous active-high reset
//     sclk_pin   : SPI clock (async), idle level CPOL
//     cs_pin     : SPI chip select, active low (async)
//     mosi_pin   : master-out data (async)
//     miso_pin   : slave-out data, high impedance unless a read is active
//     leds       : current FSM state code
module spi_memory_p
  import spi_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 7,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output wire        miso_pin,
  output logic [3:0] leds
);

  localparam int CNT_MAX     = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  // ---------------------------------------------------------------- pins
  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(sclk_pin),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .pin(cs_pin),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin(mosi_pin),
    .level(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  // SCLK edges only count while the device is selected.
  logic sample_ev, shift_ev;
  assign sample_ev = ~cs_level & (SAMPLE_RISE ? sclk_rise : sclk_fall);
  assign shift_ev  = ~cs_level & (SAMPLE_RISE ? sclk_fall : sclk_rise);

  // ---------------------------------------------------------------- state
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                miso_bit_q, miso_bit_d;
  logic                miso_oe_q, miso_oe_d;
  logic                load_q, load_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                ram_we;

  logic [ADDR_W:0]     hdr_next;
  logic [DATA_W-1:0]   wr_next;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   hdr_addr_mod;

  always_comb begin
    hdr_next     = {hdr_q, mosi_level};
    wr_next      = {shift_q[DATA_W-2:0], mosi_level};
    addr_inc     = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    // Header addresses beyond the array fold back into it.
    hdr_addr_mod = ADDR_W'(int'(hdr_next[ADDR_W:1]) % DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    miso_bit_d = miso_bit_q;
    load_d     = 1'b0;
    ram_we     = 1'b0;

    // cs rising ends the transaction from anywhere; this also discards a
    // frame whose final sample edge arrives in the same clk.
    if (cs_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_HDR;
            cnt_d   = '0;
          end
        end
        ST_HDR: begin
          if (sample_ev) begin
            hdr_d = hdr_next[ADDR_W-1:0];
            if (cnt_q == CNT_W'(ADDR_W)) begin
              cnt_d   = '0;
              addr_d  = hdr_addr_mod;
              state_d = (hdr_next[0] == RW_READ) ? ST_RD_FETCH : ST_WR;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RD_FETCH: begin
          // RAM output is valid next clk; load it into the shifter then.
          state_d = ST_RD_SHIFT;
          load_d  = 1'b1;
        end
        ST_RD_SHIFT: begin
          if (load_q) begin
            shift_d = rd_data_q;
          end else if (shift_ev) begin
            // miso_bit holds the presented bit, so the last bit of a word
            // stays on the pin while the next word is fetched.
            miso_bit_d = shift_q[DATA_W-1];
            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              addr_d  = addr_inc;
              state_d = ST_RD_FETCH;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WR: begin
          if (sample_ev) begin
            shift_d = wr_next;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              state_d = ST_WR_COMMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WR_COMMIT: begin
          ram_we  = 1'b1;
          addr_d  = addr_inc;
          state_d = ST_WR;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Registered from the next state so it tracks state_q exactly.
    miso_oe_d = (state_d == ST_RD_FETCH) || (state_d == ST_RD_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      miso_bit_q <= 1'b0;
      miso_oe_q  <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      miso_bit_q <= miso_bit_d;
      miso_oe_q  <= miso_oe_d;
      load_q     <= load_d;
    end
  end

  // ---------------------------------------------------------------- RAM
  // Contents deliberately survive reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[addr_q] <= shift_q;
    end
    rd_data_q <= mem[addr_q];
  end

  // ---------------------------------------------------------------- outputs
  assign miso_pin = miso_oe_q ? miso_bit_q : 1'bz;
  assign leds     = {1'b0, state_q};

endmodule

// File: tb/tb_spi_memory_p.sv
// tb_spi_memory_p
//   Instance 0: DATA_W=8, DEPTH=128, ADDR_W=7, mode 0.
//   Instances 1..4: DATA_W=16, DEPTH=32, ADDR_W=6, modes 0..3, so that
//   header addresses >= DEPTH exercise the modulo fold.
//   MISO nets carry a pull-up: a released line reads 1.
module tb_spi_memory_p;

  localparam int NI   = 5;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sclk_m [NI];
  logic       cs_m   [NI];
  logic       mosi_m [NI];
  wire        miso_v [NI];
  wire  [3:0] leds_v [NI];

  int checks   = 0;
  int failures = 0;
  int late_cnt = 0;
  int hp       = 4;
  logic [15:0]  exp_q [$];
  logic [127:0] rx;

  wire miso0;
  pullup (miso0);
  assign miso_v[0] = miso0;

  spi_memory_p #(
    .DATA_W(8), .DEPTH(128), .ADDR_W(7), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk_m[0]), .cs_pin(cs_m[0]),
    .mosi_pin(mosi_m[0]), .miso_pin(miso0), .leds(leds_v[0])
  );

  generate
    for (genvar gi = 1; gi < NI; gi++) begin : g_mode
      wire miso_n;
      pullup (miso_n);
      assign miso_v[gi] = miso_n;
      spi_memory_p #(
        .DATA_W(16), .DEPTH(32), .ADDR_W(6),
        .CPOL(1'(((gi - 1) >> 1) & 1)), .CPHA(1'((gi - 1) & 1)), .SYNC_STAGES(SYNC)
      ) u_dut (
        .clk(clk), .reset(reset), .sclk_pin(sclk_m[gi]), .cs_pin(cs_m[gi]),
        .mosi_pin(mosi_m[gi]), .miso_pin(miso_n), .leds(leds_v[gi])
      );
    end
  endgenerate

  function automatic bit cpol_of(input int idx);
    return (idx == 0) ? 1'b0 : 1'(((idx - 1) >> 1) & 1);
  endfunction

  function automatic bit cpha_of(input int idx);
    return (idx == 0) ? 1'b0 : 1'((idx - 1) & 1);
  endfunction

  // SPI master. Transmits tx[127] first; received bits land at the same
  // positions. MISO is also sampled one clk before each sample edge to
  // catch data that changes too late.
  task automatic spi_xfer(input int idx, input int nbits, input logic [127:0] tx,
                          input bit keep_cs, output logic [127:0] rx_o);
    bit   cpol, cpha;
    logic prev;
    cpol = cpol_of(idx);
    cpha = cpha_of(idx);
    rx_o = '0;
    cs_m[idx] = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_m[idx] = tx[127-i];
        repeat (hp - 1) @(negedge clk);
        prev = miso_v[idx];
        @(negedge clk);
        sclk_m[idx] = ~cpol;
        rx_o[127-i] = miso_v[idx];
        if (rx_o[127-i] !== prev) late_cnt++;
        repeat (hp) @(negedge clk);
        sclk_m[idx] = cpol;
      end else begin
        sclk_m[idx] = ~cpol;
        mosi_m[idx] = tx[127-i];
        repeat (hp - 1) @(negedge clk);
        prev = miso_v[idx];
        @(negedge clk);
        sclk_m[idx] = cpol;
        rx_o[127-i] = miso_v[idx];
        if (rx_o[127-i] !== prev) late_cnt++;
        repeat (hp) @(negedge clk);
      end
    end
    if (!keep_cs) begin
      if (!cpha) repeat (hp) @(negedge clk);
      cs_m[idx] = 1'b1;
      repeat (2 * hp) @(negedge clk);
    end
    $display("xfer inst=%0d mode=%0d%0d bits=%0d tx=%h rx=%h cs_held=%0d",
             idx, cpol, cpha, nbits, tx[127:64], rx_o[127:64], keep_cs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (leds_v[i] !== 4'd0) begin
        failures++;
        $display("FAIL reset_leds inst%0d: got %0d expected 0", i, leds_v[i]);
      end
    end
    checks++;
    if (miso_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_miso_released: got %b expected 1 (pulled-up z)", miso_v[0]);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] exp;
    spi_xfer(0, 16, {8'h24, 8'hA5, 112'd0}, 1'b0, rx);
    checks++;
    if (leds_v[0] !== 4'd0) begin
      failures++;
      $display("FAIL wr_idle_leds: got %0d expected 0", leds_v[0]);
    end
    checks++;
    if (miso_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL wr_miso_released: got %b expected 1", miso_v[0]);
    end
    exp_q.push_back(16'h00A5);
    spi_xfer(0, 16, {8'h25, 8'h00, 112'd0}, 1'b0, rx);
    exp = exp_q.pop_front()[7:0];
    checks++;
    if (rx[119:112] !== exp) begin
      failures++;
      $display("FAIL rd_single: got %h expected %h", rx[119:112], exp);
    end
    checks++;
    if (miso_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL rd_miso_released: got %b expected 1", miso_v[0]);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp;
    spi_xfer(0, 32, {8'hFC, 8'h11, 8'h22, 8'h33, 96'd0}, 1'b0, rx);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033);
    spi_xfer(0, 32, {8'hFD, 120'd0}, 1'b0, rx);
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front()[7:0];
      checks++;
      if (rx[119 - 8*k -: 8] !== exp) begin
        failures++;
        $display("FAIL burst_rd word%0d: got %h expected %h", k, rx[119 - 8*k -: 8], exp);
      end
    end
    exp_q.push_back(16'h0033);
    spi_xfer(0, 16, {8'h01, 120'd0}, 1'b0, rx);
    exp = exp_q.pop_front()[7:0];
    checks++;
    if (rx[119:112] !== exp) begin
      failures++;
      $display("FAIL wrap_addr0: got %h expected %h", rx[119:112], exp);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    spi_xfer(0, 16, {8'h0A, 8'h3C, 112'd0}, 1'b0, rx);
    spi_xfer(0, 13, {8'h0A, 8'hC3, 112'd0}, 1'b1, rx);
    checks++;
    if (leds_v[0] !== 4'd4) begin
      failures++;
      $display("FAIL abort_in_wr: got %0d expected 4", leds_v[0]);
    end
    cs_m[0] = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    checks++;
    if (leds_v[0] !== 4'd0) begin
      failures++;
      $display("FAIL abort_idle_latency: got %0d expected 0", leds_v[0]);
    end
    repeat (2 * hp) @(negedge clk);
    exp_q.push_back(16'h003C);
    spi_xfer(0, 16, {8'h0B, 120'd0}, 1'b0, rx);
    exp = exp_q.pop_front()[7:0];
    checks++;
    if (rx[119:112] !== exp) begin
      failures++;
      $display("FAIL abort_no_write: got %h expected %h", rx[119:112], exp);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] exp;
    spi_xfer(0, 11, {8'h25, 120'd0}, 1'b1, rx);
    checks++;
    if (leds_v[0] !== 4'd3) begin
      failures++;
      $display("FAIL midread_state: got %0d expected 3", leds_v[0]);
    end
    @(negedge clk);
    reset   = 1'b1;
    cs_m[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (leds_v[0] !== 4'd0) begin
      failures++;
      $display("FAIL midread_reset_leds: got %0d expected 0", leds_v[0]);
    end
    checks++;
    if (miso_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL midread_reset_miso: got %b expected 1", miso_v[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * hp) @(negedge clk);
    exp_q.push_back(16'h00A5);
    spi_xfer(0, 16, {8'h25, 120'd0}, 1'b0, rx);
    exp = exp_q.pop_front()[7:0];
    checks++;
    if (rx[119:112] !== exp) begin
      failures++;
      $display("FAIL post_reset_rd12: got %h expected %h", rx[119:112], exp);
    end
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    spi_xfer(0, 24, {8'hFD, 120'd0}, 1'b0, rx);
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front()[7:0];
      checks++;
      if (rx[119 - 8*k -: 8] !== exp) begin
        failures++;
        $display("FAIL post_reset_rd7e word%0d: got %h expected %h", k, rx[119 - 8*k -: 8], exp);
      end
    end
  endtask

  task automatic test_modes();
    logic [15:0] exp;
    late_cnt = 0;
    for (int idx = 1; idx < NI; idx++) begin
      spi_xfer(idx, 23, {7'h06, 16'hBEEF, 105'd0}, 1'b0, rx);
      exp_q.push_back(16'hBEEF);
      spi_xfer(idx, 23, {7'h07, 121'd0}, 1'b0, rx);
      exp = exp_q.pop_front();
      checks++;
      if (rx[120:105] !== exp) begin
        failures++;
        $display("FAIL mode_rd inst%0d: got %h expected %h", idx, rx[120:105], exp);
      end
      // address 6'h23 folds onto word 3 in a 32-word array
      exp_q.push_back(16'hBEEF);
      spi_xfer(idx, 23, {7'h47, 121'd0}, 1'b0, rx);
      exp = exp_q.pop_front();
      checks++;
      if (rx[120:105] !== exp) begin
        failures++;
        $display("FAIL mode_rd_modulo inst%0d: got %h expected %h", idx, rx[120:105], exp);
      end
    end
    checks++;
    if (late_cnt !== 0) begin
      failures++;
      $display("FAIL mode_miso_stable: got %0d late bits expected 0", late_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    hp = 4;
    spi_xfer(0, 40, {8'h80, 8'hDE, 8'hAD, 8'h5A, 8'hC3, 88'd0}, 1'b0, rx);
    exp_q.push_back(16'h00DE);
    exp_q.push_back(16'h00AD);
    exp_q.push_back(16'h005A);
    exp_q.push_back(16'h00C3);
    late_cnt = 0;
    spi_xfer(0, 40, {8'h81, 120'd0}, 1'b0, rx);
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front()[7:0];
      checks++;
      if (rx[119 - 8*k -: 8] !== exp) begin
        failures++;
        $display("FAIL fast_burst word%0d: got %h expected %h", k, rx[119 - 8*k -: 8], exp);
      end
    end
    checks++;
    if (late_cnt !== 0) begin
      failures++;
      $display("FAIL fast_burst_prefetch: got %0d late bits expected 0", late_cnt);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      sclk_m[i] = cpol_of(i);
      cs_m[i]   = 1'b1;
      mosi_m[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_abort();
    test_reset_mid_read();
    test_modes();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
